// File: rtl/recovery_tx_arbiter.sv
// -----------------------------------------------------------------------------
// recovery_tx_arbiter
//
// Shares the single read-response transmit path between NumSrc producers
// (source 0 = recovery command executor, source 1 = TTI TX path). One source
// is granted per transaction. Its length descriptor and byte stream are passed
// straight through to the transmit engine, and the stream is cut at the
// descriptor length. A host NACK or a dlast/length mismatch ends the
// transaction. Any bytes the source still holds are then drained and discarded.
//
// Ports
//   clk_i, rst_i          clock, asynchronous active-high reset
//   src_res_valid_i/len_i per-source descriptor request (len slice i*LenWidth)
//   src_res_ready_o       descriptor accept, only towards the granted source
//   src_dvalid_i/data_i/dlast_i  per-source byte stream (data slice i*8)
//   src_dready_o          byte accept, only towards the granted source
//   src_done_o            one-cycle pulse when the granted source is released
//   res_valid_o/ready_i/len_o    descriptor towards the transmit engine
//   res_dvalid_o/dready_i/data_o/dlast_o  byte stream towards the engine
//   tx_host_nack_i        host terminated the read (honoured only in Data)
//   abort_o, len_err_o    registered one-cycle pulses
//   grant_o, busy_o       current grant index, state is not Idle
// -----------------------------------------------------------------------------
module recovery_tx_arbiter #(
   parameter int NumSrc     = 2,
   parameter int LenWidth   = 16,
   parameter bit RoundRobin = 1'b1
) (
   input  logic                         clk_i,
   input  logic                         rst_i,
   input  logic [NumSrc-1:0]            src_res_valid_i,
   input  logic [NumSrc*LenWidth-1:0]   src_res_len_i,
   output logic [NumSrc-1:0]            src_res_ready_o,
   input  logic [NumSrc-1:0]            src_dvalid_i,
   input  logic [NumSrc*8-1:0]          src_data_i,
   input  logic [NumSrc-1:0]            src_dlast_i,
   output logic [NumSrc-1:0]            src_dready_o,
   output logic [NumSrc-1:0]            src_done_o,
   output logic                         res_valid_o,
   input  logic                         res_ready_i,
   output logic [LenWidth-1:0]          res_len_o,
   output logic                         res_dvalid_o,
   input  logic                         res_dready_i,
   output logic [7:0]                   res_data_o,
   output logic                         res_dlast_o,
   input  logic                         tx_host_nack_i,
   output logic                         abort_o,
   output logic                         len_err_o,
   output logic [$clog2(NumSrc)-1:0]    grant_o,
   output logic                         busy_o
);

   localparam int GW    = $clog2(NumSrc);
   localparam int ByteW = 8;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_DESC    = 3'd1,
      ST_DATA    = 3'd2,
      ST_DRAIN   = 3'd3,
      ST_RELEASE = 3'd4
   } state_e;

   state_e                state_r;
   logic [GW-1:0]         grant_r;
   logic [GW-1:0]         rr_ptr_r;
   logic [LenWidth-1:0]   bcnt_r;
   logic                  abort_r;
   logic                  len_err_r;
   logic [NumSrc-1:0]     done_r;
   logic                  busy_r;

   logic [GW-1:0]         start_s;
   logic [GW-1:0]         cand_s;
   logic [GW-1:0]         winner_s;
   logic                  found_s;
   logic [GW-1:0]         next_ptr_s;
   logic [NumSrc-1:0]     grant_oh_s;
   logic                  sel_valid_s;
   logic [LenWidth-1:0]   sel_len_s;
   logic                  sel_dvalid_s;
   logic [7:0]            sel_data_s;
   logic                  sel_dlast_s;
   logic                  desc_hs_s;
   logic                  beat_s;
   logic                  bcnt_one_s;
   logic                  drain_end_s;

   // One-hot decode of a source index.
   function automatic logic [NumSrc-1:0] onehot(input logic [GW-1:0] idx);
      logic [NumSrc-1:0] v;
      v      = {NumSrc{1'b0}};
      v[idx] = 1'b1;
      return v;
   endfunction

   // Granted-source selection; the grant register is only changed in Idle,
   // so these muxes are stable for the whole transaction.
   assign grant_oh_s   = onehot(grant_r);
   assign sel_valid_s  = src_res_valid_i[grant_r];
   assign sel_len_s    = src_res_len_i[int'(grant_r)*LenWidth +: LenWidth];
   assign sel_dvalid_s = src_dvalid_i[grant_r];
   assign sel_data_s   = src_data_i[int'(grant_r)*ByteW +: ByteW];
   assign sel_dlast_s  = src_dlast_i[grant_r];

   assign desc_hs_s   = (state_r == ST_DESC) & sel_valid_s & res_ready_i;
   assign beat_s      = (state_r == ST_DATA) & sel_dvalid_s & res_dready_i;
   assign bcnt_one_s  = (bcnt_r == {{(LenWidth-1){1'b0}}, 1'b1});
   assign drain_end_s = (state_r == ST_DRAIN) & sel_dvalid_s & sel_dlast_s;

   // Fixed mode always searches from index 0.
   assign start_s    = RoundRobin ? rr_ptr_r : {GW{1'b0}};
   assign next_ptr_s = (grant_r == GW'(NumSrc-1)) ? {GW{1'b0}} : (grant_r + {{(GW-1){1'b0}}, 1'b1});

   // Circular search for the first requesting source starting at start_s.
   always_comb begin
      winner_s = {GW{1'b0}};
      found_s  = 1'b0;
      cand_s   = {GW{1'b0}};
      for (int i = 0; i < NumSrc; i++) begin
         cand_s   = GW'((int'(start_s) + i) % NumSrc);
         winner_s = (!found_s && src_res_valid_i[cand_s]) ? cand_s : winner_s;
         found_s  = found_s | src_res_valid_i[cand_s];
      end
   end

   // Zero-latency pass-through of the granted source, gated by state.
   always_comb begin
      res_valid_o     = 1'b0;
      res_len_o       = {LenWidth{1'b0}};
      src_res_ready_o = {NumSrc{1'b0}};
      res_dvalid_o    = 1'b0;
      res_data_o      = 8'h00;
      res_dlast_o     = 1'b0;
      src_dready_o    = {NumSrc{1'b0}};
      case (state_r)
         ST_DESC: begin
            res_valid_o     = sel_valid_s;
            res_len_o       = sel_len_s;
            src_res_ready_o = grant_oh_s & {NumSrc{res_ready_i}};
         end
         ST_DATA: begin
            res_dvalid_o = sel_dvalid_s;
            res_data_o   = sel_data_s;
            // Terminate the engine-side stream at the descriptor length even
            // when the source intends to send more.
            res_dlast_o  = sel_dvalid_s & (bcnt_one_s | sel_dlast_s);
            src_dready_o = grant_oh_s & {NumSrc{res_dready_i}};
         end
         ST_DRAIN: begin
            // Swallow the rest of the source's stream without forwarding it.
            src_dready_o = grant_oh_s;
         end
         default: begin
            res_valid_o = 1'b0;
         end
      endcase
   end

   // Transaction state machine with its registered outputs.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_r   <= ST_IDLE;
         grant_r   <= {GW{1'b0}};
         rr_ptr_r  <= {GW{1'b0}};
         bcnt_r    <= {LenWidth{1'b0}};
         abort_r   <= 1'b0;
         len_err_r <= 1'b0;
         done_r    <= {NumSrc{1'b0}};
         busy_r    <= 1'b0;
      end else begin
         abort_r   <= 1'b0;
         len_err_r <= 1'b0;
         done_r    <= {NumSrc{1'b0}};
         case (state_r)
            ST_IDLE: begin
               if (found_s) begin
                  grant_r <= winner_s;
                  state_r <= ST_DESC;
                  busy_r  <= 1'b1;
               end else begin
                  busy_r  <= 1'b0;
               end
            end
            ST_DESC: begin
               if (desc_hs_s) begin
                  bcnt_r <= sel_len_s;
                  if (sel_len_s == {LenWidth{1'b0}}) begin
                     state_r <= ST_RELEASE;
                     done_r  <= grant_oh_s;
                  end else begin
                     state_r <= ST_DATA;
                  end
               end
            end
            ST_DATA: begin
               // A beat accepted in a NACK cycle still counts as sent.
               if (beat_s && (bcnt_r != {LenWidth{1'b0}})) begin
                  bcnt_r <= bcnt_r - {{(LenWidth-1){1'b0}}, 1'b1};
               end
               if (tx_host_nack_i) begin
                  abort_r <= 1'b1;
                  if (beat_s && sel_dlast_s) begin
                     state_r <= ST_RELEASE;
                     done_r  <= grant_oh_s;
                  end else begin
                     state_r <= ST_DRAIN;
                  end
               end else if (beat_s) begin
                  if (bcnt_one_s) begin
                     if (sel_dlast_s) begin
                        state_r <= ST_RELEASE;
                        done_r  <= grant_oh_s;
                     end else begin
                        // Source has more bytes than it announced.
                        len_err_r <= 1'b1;
                        state_r   <= ST_DRAIN;
                     end
                  end else if (sel_dlast_s) begin
                     // Source ended before the announced length.
                     len_err_r <= 1'b1;
                     state_r   <= ST_RELEASE;
                     done_r    <= grant_oh_s;
                  end
               end
            end
            ST_DRAIN: begin
               if (drain_end_s) begin
                  state_r <= ST_RELEASE;
                  done_r  <= grant_oh_s;
               end
            end
            ST_RELEASE: begin
               rr_ptr_r <= next_ptr_s;
               state_r  <= ST_IDLE;
               busy_r   <= 1'b0;
            end
            default: begin
               state_r <= ST_IDLE;
               busy_r  <= 1'b0;
            end
         endcase
      end
   end

   assign abort_o    = abort_r;
   assign len_err_o  = len_err_r;
   assign src_done_o = done_r;
   assign grant_o    = grant_r;
   assign busy_o     = busy_r;

endmodule

// File: tb/tb_recovery_tx_arbiter.sv
module tb_recovery_tx_arbiter;

   localparam int N  = 2;
   localparam int LW = 16;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic [N-1:0]    src_res_valid, src_res_ready, src_dvalid, src_dlast, src_dready, src_done;
   logic [N*LW-1:0] src_res_len;
   logic [N*8-1:0]  src_data;
   logic            res_valid, res_ready, res_dvalid, res_dready, res_dlast, nack;
   logic            abort, len_err, busy;
   logic [LW-1:0]   res_len;
   logic [7:0]      res_data;
   logic [0:0]      grant;

   logic [N-1:0]    fp_src_res_ready, fp_src_dready, fp_src_done;
   logic            fp_res_valid, fp_res_dvalid, fp_res_dlast, fp_abort, fp_len_err, fp_busy;
   logic [LW-1:0]   fp_res_len;
   logic [7:0]      fp_res_data;
   logic [0:0]      fp_grant;

   recovery_tx_arbiter #(.NumSrc(N), .LenWidth(LW), .RoundRobin(1'b1)) dut (
      .clk_i(clk), .rst_i(rst),
      .src_res_valid_i(src_res_valid), .src_res_len_i(src_res_len), .src_res_ready_o(src_res_ready),
      .src_dvalid_i(src_dvalid), .src_data_i(src_data), .src_dlast_i(src_dlast),
      .src_dready_o(src_dready), .src_done_o(src_done),
      .res_valid_o(res_valid), .res_ready_i(res_ready), .res_len_o(res_len),
      .res_dvalid_o(res_dvalid), .res_dready_i(res_dready), .res_data_o(res_data), .res_dlast_o(res_dlast),
      .tx_host_nack_i(nack), .abort_o(abort), .len_err_o(len_err), .grant_o(grant), .busy_o(busy));

   // Fixed-priority instance: both sources request zero-length responses forever.
   recovery_tx_arbiter #(.NumSrc(N), .LenWidth(LW), .RoundRobin(1'b0)) dut_fp (
      .clk_i(clk), .rst_i(rst),
      .src_res_valid_i(2'b11), .src_res_len_i(32'd0), .src_res_ready_o(fp_src_res_ready),
      .src_dvalid_i(2'b00), .src_data_i(16'h0000), .src_dlast_i(2'b00),
      .src_dready_o(fp_src_dready), .src_done_o(fp_src_done),
      .res_valid_o(fp_res_valid), .res_ready_i(1'b1), .res_len_o(fp_res_len),
      .res_dvalid_o(fp_res_dvalid), .res_dready_i(1'b1), .res_data_o(fp_res_data), .res_dlast_o(fp_res_dlast),
      .tx_host_nack_i(1'b0), .abort_o(fp_abort), .len_err_o(fp_len_err), .grant_o(fp_grant), .busy_o(fp_busy));

   // ---------------- reference model state ----------------
   int total = 0, bad = 0, cyc = 0;
   bit   active_m[N], acc_m[N], nack_en_m[N], nack_done_m[N];
   int   len_m[N], nb_m[N], sent_m[N], nack_at_m[N];
   logic [7:0] bytes_m[N][16];
   logic [7:0] fwd_q[$];
   bit         fwd_last_q[$];
   int   grant_log[$];
   int   lenerr_cnt = 0, start_cyc = 0, nack_cyc = -10, done_cnt = 0, fp_done_cnt = 0;
   int   ptr_m = 0, auto_len = -1;
   logic [N-1:0] prev_req = '0;
   bit   busy_prev = 0, fp_busy_prev = 0, auto_mode = 0, rand_rdy = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int min2(input int a, input int b);
      return (a < b) ? a : b;
   endfunction

   function automatic int owner();
      for (int i = 0; i < N; i++) if (active_m[i] && acc_m[i]) return i;
      return -1;
   endfunction

   // First requester at or after ptr, wrapping.
   function automatic int exp_winner(input logic [N-1:0] req, input int ptr);
      for (int k = 0; k < N; k++) if (req[(ptr + k) % N]) return (ptr + k) % N;
      return -1;
   endfunction

   task automatic start_txn(input int s, input int len, input int nb, input int nack_at);
      active_m[s] = 1; acc_m[s] = 0; len_m[s] = len; nb_m[s] = nb; sent_m[s] = 0;
      nack_en_m[s] = (nack_at >= 0); nack_at_m[s] = nack_at; nack_done_m[s] = 0;
      for (int j = 0; j < 16; j++) bytes_m[s][j] = 8'($urandom);
   endtask

   task automatic random_txn(input int s);
      int len, nb, na;
      len = (auto_len >= 0) ? auto_len : int'($urandom_range(0, 6));
      nb  = (len == 0) ? 0 : (($urandom_range(0, 1) == 1) ? len : int'($urandom_range(1, 8)));
      na  = -1;
      if (auto_len < 0 && min2(len, nb) >= 2 && $urandom_range(0, 3) == 0)
         na = int'($urandom_range(0, min2(len, nb) - 2));
      start_txn(s, len, nb, na);
   endtask

   // Transaction-level expectations, evaluated on the release pulse.
   task automatic eval_done(input int o);
      int k, kexp;
      bit bytes_ok, last_ok;
      k = fwd_q.size(); bytes_ok = 1; last_ok = 1;
      for (int j = 0; j < k; j++) if (fwd_q[j] !== bytes_m[o][j]) bytes_ok = 0;
      if (nack_en_m[o]) begin
         chk("nack_fwd_count", (k == nack_at_m[o] || k == nack_at_m[o] + 1), 1);
         for (int j = 0; j < k; j++) if (fwd_last_q[j]) last_ok = 0;
         chk("len_err_count", lenerr_cnt, 0);
      end else begin
         kexp = (len_m[o] == 0) ? 0 : min2(len_m[o], nb_m[o]);
         chk("fwd_count", k, kexp);
         for (int j = 0; j < k; j++) if (fwd_last_q[j] != (j == k - 1)) last_ok = 0;
         chk("len_err_count", lenerr_cnt, (len_m[o] > 0 && len_m[o] != nb_m[o]) ? 1 : 0);
      end
      chk("fwd_bytes", bytes_ok, 1);
      chk("fwd_dlast", last_ok, 1);
      chk("src_bytes_consumed", sent_m[o], nb_m[o]);
      if (!rand_rdy && len_m[o] == 0) chk("len0_release_latency", cyc - start_cyc, 1);
      ptr_m = (o + 1) % N;
      active_m[o] = 0; acc_m[o] = 0;
      grant_log.push_back(o);
      done_cnt++;
   endtask

   // One clock cycle: drive at the falling edge, observe 2ns later.
   task automatic step();
      int o;
      logic [N-1:0] omask;
      @(negedge clk);
      if (auto_mode) for (int i = 0; i < N; i++) if (!active_m[i]) random_txn(i);
      o = owner();
      for (int i = 0; i < N; i++) begin
         src_res_valid[i]      = active_m[i] & !acc_m[i];
         src_res_len[i*LW +: LW] = 16'(len_m[i]);
         src_dvalid[i]         = active_m[i] && acc_m[i] && (sent_m[i] < nb_m[i]) &&
                                 (!rand_rdy || $urandom_range(0, 3) != 0);
         src_data[i*8 +: 8]    = bytes_m[i][sent_m[i] % 16];
         src_dlast[i]          = src_dvalid[i] && (sent_m[i] == nb_m[i] - 1);
      end
      res_ready  = !rand_rdy || ($urandom_range(0, 2) != 0);
      res_dready = !rand_rdy || ($urandom_range(0, 2) != 0);
      nack = 1'b0;
      if (o >= 0 && nack_en_m[o] && !nack_done_m[o] && fwd_q.size() == nack_at_m[o]) begin
         nack = 1'b1; nack_done_m[o] = 1; nack_cyc = cyc;
      end else if (o < 0 && rand_rdy) begin
         nack = ($urandom_range(0, 4) == 0);   // Idle/Desc: must be ignored
      end
      #2;
      if (busy && !busy_prev) begin
         chk("grant", grant, exp_winner(prev_req, ptr_m));
         fwd_q.delete(); fwd_last_q.delete();
         lenerr_cnt = 0; start_cyc = cyc;
      end
      chk("abort_pulse", abort, (nack_cyc >= 0 && cyc == nack_cyc + 1));
      if (len_err) lenerr_cnt++;
      o = owner();
      omask = (o >= 0) ? N'(1 << o) : '0;
      chk("dready_only_owner", src_dready & ~omask, 0);
      chk("rready_only_requester", src_res_ready & ~src_res_valid, 0);
      if (res_dvalid) begin
         chk("dvalid_has_owner", (o >= 0), 1);
         if (o >= 0) chk("data_passthru", res_data, bytes_m[o][sent_m[o] % 16]);
      end
      for (int i = 0; i < N; i++) begin
         if (src_res_valid[i] && src_res_ready[i]) begin
            chk("res_valid", res_valid, 1);
            chk("res_len", res_len, len_m[i]);
            acc_m[i] = 1;
         end
         if (src_dvalid[i] && src_dready[i]) sent_m[i]++;
      end
      if (res_dvalid && res_dready) begin
         fwd_q.push_back(res_data); fwd_last_q.push_back(res_dlast);
      end
      if (src_done != '0) begin
         chk("done_source", src_done, omask);
         if (o >= 0) eval_done(o);
      end
      if (fp_busy && !fp_busy_prev) chk("fp_grant_lowest", fp_grant, 0);
      if (fp_src_done != '0) begin
         chk("fp_done_src0", fp_src_done, 2'b01);
         fp_done_cnt++;
      end
      chk("fp_idle_paths", {fp_res_dvalid, fp_abort, fp_len_err, fp_src_dready, fp_res_data, fp_res_dlast, fp_res_len}, 0);
      chk("fp_desc_ready", fp_src_res_ready, fp_res_valid ? 2'b01 : 2'b00);
      prev_req = src_res_valid; busy_prev = busy; fp_busy_prev = fp_busy;
      cyc++;
   endtask

   task automatic wait_done(input int d0, input int want, input int budget);
      for (int t = 0; t < budget && done_cnt < d0 + want; t++) step();
      chk("txn_complete", done_cnt - d0, want);
   endtask

   task automatic wait_idle();
      for (int t = 0; t < 400 && (active_m[0] || active_m[1]); t++) step();
      chk("drained_to_idle", {active_m[0], active_m[1]}, 2'b00);
   endtask

   initial begin
      int d0;
      rst = 1'b1; src_res_valid = '0; src_res_len = '0; src_dvalid = '0; src_data = '0;
      src_dlast = '0; res_ready = 1'b0; res_dready = 1'b0; nack = 1'b0;
      #12;
      chk("reset_outputs", {src_res_ready, src_dready, src_done, res_valid, res_len, res_dvalid,
                            res_data, res_dlast, abort, len_err, grant, busy}, 0);
      chk("reset_fp_busy", {fp_busy, fp_grant, fp_src_done}, 0);
      @(negedge clk); rst = 1'b0;

      // Source 0, len 3, A1 A2 A3
      d0 = done_cnt; start_txn(0, 3, 3, -1);
      bytes_m[0][0] = 8'hA1; bytes_m[0][1] = 8'hA2; bytes_m[0][2] = 8'hA3;
      wait_done(d0, 1, 60);
      chk("t1_bytes", {fwd_q[0], fwd_q[1], fwd_q[2]}, 24'hA1A2A3);
      // Source 1, zero length
      d0 = done_cnt; start_txn(1, 0, 0, -1); wait_done(d0, 1, 60);
      // Source ends early: len 4, dlast on byte 2
      d0 = done_cnt; start_txn(0, 4, 2, -1); wait_done(d0, 1, 60);
      // Source overruns: len 2, 5 bytes
      d0 = done_cnt; start_txn(0, 2, 5, -1); wait_done(d0, 1, 60);
      // NACK after byte 1 of len 4
      d0 = done_cnt; start_txn(1, 4, 4, 1); wait_done(d0, 1, 60);

      // Both sources request continuously, len 2 each: grants alternate
      auto_mode = 1; auto_len = 2; d0 = done_cnt;
      wait_done(d0, 6, 200);
      auto_mode = 0; wait_idle();
      for (int j = grant_log.size() - 5; j < grant_log.size(); j++)
         chk("rr_alternate", grant_log[j] != grant_log[j-1], 1);

      // Randomized traffic with back-pressure, gaps and NACKs
      auto_mode = 1; auto_len = -1; rand_rdy = 1; d0 = done_cnt;
      wait_done(d0, 60, 6000);
      auto_mode = 0; wait_idle();
      rand_rdy = 0;

      // Asynchronous reset in the middle of Data
      start_txn(0, 4, 4, -1);
      for (int t = 0; t < 60 && fwd_q.size() < 1; t++) step();
      chk("reached_data", fwd_q.size() >= 1, 1);
      rst = 1'b1;
      #1;
      chk("async_reset_outputs", {src_res_ready, src_dready, src_done, res_valid, res_len, res_dvalid,
                                  res_data, res_dlast, abort, len_err, grant, busy}, 0);
      for (int i = 0; i < N; i++) begin active_m[i] = 0; acc_m[i] = 0; end
      src_res_valid = '0; src_dvalid = '0; src_dlast = '0; nack = 1'b0;
      ptr_m = 0; prev_req = '0; busy_prev = 0; fp_busy_prev = 0; nack_cyc = -10;
      fwd_q.delete(); fwd_last_q.delete();
      @(posedge clk); @(posedge clk); #1;
      chk("reset_held_quiet", {src_done, abort, len_err, busy}, 0);
      @(negedge clk); rst = 1'b0;
      d0 = done_cnt; start_txn(1, 3, 3, -1); wait_done(d0, 1, 60);

      chk("fp_done_seen", fp_done_cnt > 10, 1);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
